imm_encoder: RTL and testbench

- Pipelined immediate encoder. It takes a base RV32 instruction word whose immediate bit positions are don't-care, plus a 32-bit immediate and a format selector, and emits the instruction with the immediate scattered into the correct bit fields.
- It is the exact inverse of the decode-stage immediate generator and uses the same 3-bit ImmSrc encoding.
- It is used by the self-test instruction sequencer and the compliance-patch loader.
- It sits between the producer and instruction memory write port, with valid/ready handshakes on both sides.

---
 rtl/core_pkg.sv | 29 ++
 rtl/imm_pack.sv | 47 ++++
 rtl/imm_encoder.sv | 96 +++++++++
 tb/tb_imm_encoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the immediate encoder: ImmSrc codes, range limits, S1 entry layout.
// The range limits are only consumed when IMM_RANGE_CHECK_EN is defined.
package core_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM_B_MIN = -4096;
  localparam int signed IMM_B_MAX = 4094;
  localparam int signed IMM_J_MIN = -1048576;
  localparam int signed IMM_J_MAX = 1048574;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  immsrc;
  } s1_entry_t;

  function automatic logic imm_outside(input logic [31:0] imm, input int signed lo,
                                       input int signed hi);
    return ($signed(imm) < lo) || ($signed(imm) > hi);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: scatters an immediate into an RV32 instruction word.
// Optional IMM_RANGE_CHECK_EN flags immediates not representable in the selected format.
module imm_pack
  import core_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] imm_i,
  input  logic [2:0]  immsrc_i,
  output logic [31:0] inst_o,
  output logic        err_o
);

  logic illegal;
  logic range_err;

  always_comb begin
    inst_o  = inst_i;
    illegal = 1'b0;
    case (immsrc_i)
      IMM_I:   inst_o = {imm_i[11:0], inst_i[19:0]};
      IMM_S:   inst_o = {imm_i[11:5], inst_i[24:12], imm_i[4:0], inst_i[6:0]};
      IMM_B:   inst_o = {imm_i[12], imm_i[10:5], inst_i[24:12], imm_i[4:1], imm_i[11],
                         inst_i[6:0]};
      IMM_J:   inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], inst_i[11:0]};
      IMM_U:   inst_o = {imm_i[31:12], inst_i[11:0]};
      default: illegal = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    range_err = 1'b0;
    case (immsrc_i)
      IMM_I, IMM_S: range_err = imm_outside(imm_i, IMM12_MIN, IMM12_MAX);
      IMM_B:        range_err = imm_outside(imm_i, IMM_B_MIN, IMM_B_MAX) || imm_i[0];
      IMM_J:        range_err = imm_outside(imm_i, IMM_J_MIN, IMM_J_MAX) || imm_i[0];
      IMM_U:        range_err = (imm_i[11:0] != 12'h000);
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign err_o = illegal || range_err;

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder with valid/ready on both sides (S1 = captured request, S2 = packed result).
// Define IMM_RANGE_CHECK_EN to also flag out-of-range immediates on out_err.
module imm_encoder
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_inst,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [2:0]       in_immsrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  logic             s1_valid_q, s1_valid_d;
  s1_entry_t        s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_inst_q, s2_inst_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        s2_adv;
  logic        s1_adv;
  logic [31:0] pack_inst;
  logic        pack_err;

  // S1 may refill in the same cycle S2 drains, so in_ready looks through to out_ready.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  imm_pack u_pack (
    .inst_i   (s1_q.inst),
    .imm_i    (s1_q.imm),
    .immsrc_i (s1_q.immsrc),
    .inst_o   (pack_inst),
    .err_o    (pack_err)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_inst_d  = s2_inst_q;
    s2_err_d   = s2_err_q;
    cnt_d      = cnt_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = '{inst: in_inst, imm: in_imm, immsrc: in_immsrc};
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_d = pack_inst;
        s2_err_d  = pack_err;
      end
    end
    if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_inst_q  <= s2_inst_d;
      s2_err_q   <= s2_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign enc_count = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: driver pushes model results, negedge monitor pops and compares.
// Honours IMM_RANGE_CHECK_EN in its reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_imm = '0;
  logic [2:0]  in_immsrc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;

  int          num_chk = 0;
  int          num_err = 0;
  logic [32:0] exp_q[$];
  int          model_cnt = 0;
  bit          rnd_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_inst = '0;
  logic        prev_err = 1'b0;

  imm_encoder #(.XLEN(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_imm    (in_imm),
    .in_immsrc (in_immsrc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_chk++;
    if (act !== exp) begin
      num_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: clear the format's immediate bit positions, then OR in the shifted immediate slices.
  function automatic logic [32:0] model(input logic [31:0] inst, input logic [31:0] imm,
                                        input logic [2:0] src);
    logic [31:0] r;
    logic        err;
    int signed   s;
    s   = $signed(imm);
    err = 1'b0;
    case (src)
      3'd0: r = (inst & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
      3'd1: r = (inst & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      3'd2: r = (inst & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
              | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
              | (((imm >> 11) & 32'h1) << 7);
      3'd3: r = (inst & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
              | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
              | (((imm >> 12) & 32'hFF) << 12);
      3'd4: r = (inst & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
      default: begin
        r   = inst;
        err = 1'b1;
      end
    endcase
`ifdef IMM_RANGE_CHECK_EN
    case (src)
      3'd0, 3'd1: if (s < -2048 || s > 2047) err = 1'b1;
      3'd2:       if (s < -4096 || s > 4094 || (s % 2) != 0) err = 1'b1;
      3'd3:       if (s < -1048576 || s > 1048574 || (s % 2) != 0) err = 1'b1;
      3'd4:       if ((imm % 4096) != 0) err = 1'b1;
      default:    ;
    endcase
`else
    if (s == 0) err = err;
`endif
    return {err, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] imm, input logic [2:0] src,
                      output int waits);
    bit acc;
    in_valid  = 1'b1;
    in_inst   = inst;
    in_imm    = imm;
    in_immsrc = src;
    waits     = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        exp_q.push_back(model(inst, imm, src));
        break;
      end
      waits++;
      if (waits > 300) begin
        num_chk++;
        num_err++;
        $display("FAIL accept_timeout inst=%h", inst);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      check("enc_count", 32'(enc_count), 32'(model_cnt));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_inst", out_inst, prev_inst);
        check("hold_err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          num_chk++;
          num_err++;
          $display("FAIL unexpected_output actual=%h required=none", out_inst);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("out_inst", out_inst, e[31:0]);
          check("out_err", 32'(out_err), 32'(e[32]));
        end
        model_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_inst  = out_inst;
      prev_err   = out_err;
    end
  end

  initial begin
    int w;
    logic [31:0] imm;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // I-type with latency probe
    out_ready = 1'b1;
    send(32'h0000_0093, 32'hFFFF_FFFF, 3'b000, w);
    check("lat_not_early", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_i_inst", out_inst, 32'hFFF0_0093);
    drain();

    // S then B back-to-back
    send(32'h0020_A023, 32'd8, 3'b001, w);
    send(32'h0000_0063, 32'hFFFF_FFFC, 3'b010, w);
    check("b2b_no_stall", 32'(w), 32'd0);
    drain();

    // J and U
    send(32'h0000_006F, 32'd8, 3'b011, w);
    send(32'h0000_02B7, 32'h1234_5000, 3'b100, w);
    drain();
    check("count_after_ju", 32'(enc_count), 32'd5);

    // Backpressure: two accepted, third blocked while output holds
    out_ready = 1'b0;
    send(32'h0000_0013, 32'd1, 3'b000, w);
    send(32'h0000_0013, 32'd2, 3'b000, w);
    in_valid  = 1'b1;
    in_inst   = 32'h0000_0013;
    in_imm    = 32'd3;
    in_immsrc = 3'b000;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_first_held", out_inst, 32'h0010_0013);
      tick();
    end
    out_ready = 1'b1;
    send(32'h0000_0013, 32'd3, 3'b000, w);
    drain();

    // Illegal source and range boundary
    send(32'hDEAD_BEEF, 32'h0000_0FFF, 3'b101, w);
    send(32'h0000_0093, 32'd2048, 3'b000, w);
    send(32'h0000_0093, 32'd2047, 3'b000, w);
    send(32'h0000_0063, 32'd4094, 3'b010, w);
    send(32'h0000_0063, 32'd3, 3'b010, w);
    drain();

    // Randomised traffic with random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) imm = $urandom;
      else imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      send($urandom, imm, 3'($urandom_range(0, 7)), w);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two entries in flight
    out_ready = 1'b0;
    send(32'h0000_0093, 32'd5, 3'b000, w);
    send(32'h0000_0093, 32'd6, 3'b000, w);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_enc_count", 32'(enc_count), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      tick();
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    check("post_rst_count", 32'(enc_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", num_err, num_chk);
    $finish;
  end

endmodule
